vending_machine: RTL and testbench
==================================

Name: vending_machine

Overview:
Card-operated vending-machine controller. It keeps a stock count per item slot. A transaction runs as: card in, two-digit item code on the keypad, cost display, bank validation, vend. Sits between the keypad/card-reader front end and the dispense/bank interfaces. Pure control plus a small inventory array; no datapath outside it.

Parameters:
TIMEOUT_CYCLES, 5, idle cycles allowed while waiting for each digit and for VALID_TRAN
STOCK_PER_ITEM, 10, count loaded into every valid slot on RELOAD
MAX_CODE, 25, highest valid decimal item code

Ports:
CLK  input  1  system clock; all state changes on rising edge
RESET  input  1  asynchronous, active-low reset; RESET=0 forces reset state
RELOAD  input  1  restock request, honoured only in IDLE
CARD_IN  input  1  card present
ITEM_CODE  input  3  keypad digit 0..7, sampled when KEY_PRESS=1
KEY_PRESS  input  1  digit strobe, one cycle per digit
VALID_TRAN  input  1  bank approval of the transaction
VEND  output  1  dispense strobe
INVALID_SEL  output  1  selection rejected
COST  output  3  price of the selected item
FAILED_TRAN  output  1  bank approval not received in time

Behaviour:
- RESET=0 (async): all stock counts=0, state=IDLE, VEND=INVALID_SEL=FAILED_TRAN=0, COST=0, digit and timeout registers cleared.
- States: IDLE, RELOAD_ST, GET_D1, GET_D2, CHECK, WAIT_VALID, VEND_ST, INVALID_ST, FAIL_ST. All outputs are registered.
- IDLE:
  - RELOAD=1 -> RELOAD_ST. RELOAD has priority over CARD_IN.
  - Else CARD_IN=1 -> GET_D1.
  - All outputs are 0 in IDLE.
- RELOAD_ST: sets every slot with code ≤ MAX_CODE to STOCK_PER_ITEM, then -> IDLE next cycle.
- GET_D1:
  - KEY_PRESS=1 latches ITEM_CODE as the tens digit -> GET_D2, timeout counter cleared.
  - Each cycle without KEY_PRESS increments the counter. After TIMEOUT_CYCLES cycles without a press -> INVALID_ST.
- GET_D2: same rules; latches the units digit -> CHECK.
- CHECK (1 cycle):
  - code = tens*10 + units.
  - Valid iff code ≤ MAX_CODE and stock[code] > 0. Valid -> WAIT_VALID, else -> INVALID_ST.
  - Reachable valid codes: 00-07, 10-17, 20-25.
- Cost table by code: 00-03=1, 04-07=2, 10-13=3, 14-17=4, 20-22=5, 23-25=6.
- WAIT_VALID:
  - COST driven with the table value.
  - VALID_TRAN=1 within TIMEOUT_CYCLES cycles -> VEND_ST.
  - Otherwise -> FAIL_ST.
- VEND_ST (1 cycle): VEND=1, COST held, stock[code] decremented by 1 (never below 0), then -> IDLE.
- INVALID_ST: INVALID_SEL=1 for exactly one cycle, COST=0 -> IDLE.
- FAIL_ST: FAILED_TRAN=1 for exactly one cycle, COST=0 -> IDLE.
- Input handling:
  - KEY_PRESS and RELOAD are ignored outside the states that consume them.
  - VALID_TRAN is ignored outside WAIT_VALID.
  - CARD_IN is only examined in IDLE. If CARD_IN is still high on return to IDLE, a new transaction starts the next cycle.
- Stock counts are 4-bit and persist across transactions; only RESET or RELOAD changes them wholesale.
- RESET mid-transaction aborts immediately with the reset values above; stock is cleared.

Decomposition:
- Package vending_pkg: state enum; constants TIMEOUT_CYCLES, STOCK_PER_ITEM, MAX_CODE; cost-lookup function (code -> 3-bit cost); code-validity function.
- One sub-module, vending_inventory:
  - Holds the stock array, indexed by decimal code 0..MAX_CODE.
  - Ports: clear, reload, decrement + index, read count.
- The FSM stays in vending_machine.

Test Plan:
- Reset (RESET=0), then RELOAD pulse, CARD_IN, digits 2,2, VALID_TRAN within 5 cycles -> COST=5 in WAIT_VALID; VEND=1 for one cycle; stock[22]=9.
- Reset with no RELOAD, then card, digits 2,2, VALID_TRAN -> INVALID_SEL=1 one cycle, VEND never asserts.
- Reload, card, digits 2,2, VALID_TRAN held 0 for 5+ cycles -> FAILED_TRAN=1 one cycle, VEND=0, return to IDLE.
- Reload, card, digits 2,7 -> INVALID_SEL=1, COST stays 0. Separately, digits 1,0 -> COST=3.
- Reload, card, digit 2, then no KEY_PRESS for 5 cycles -> INVALID_SEL=1 and IDLE. A late second press is ignored, or starts a new GET_D1 if CARD_IN is high.
- Reload, CARD_IN and VALID_TRAN held high, eleven consecutive 2,2 selections -> VEND on the first 10, INVALID_SEL on the 11th; stock[22]=0.

Source files
------------

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared states, constants and price/validity helpers for the vending controller
package vending_pkg;

  localparam int TIMEOUT_CYCLES = 5;
  localparam int STOCK_PER_ITEM = 10;
  localparam int MAX_CODE       = 25;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE,
    RELOAD_ST,
    GET_D1,
    GET_D2,
    CHECK,
    WAIT_VALID,
    VEND_ST,
    INVALID_ST,
    FAIL_ST
  } state_t;

  function automatic logic code_in_range(input logic [6:0] code);
    return code <= 7'(MAX_CODE);
  endfunction

  // Codes 08/09/18/19 cannot be keyed in, so they fall through to a zero price.
  function automatic logic [2:0] cost_of(input logic [6:0] code);
    logic [2:0] c;
    c = 3'd0;
    if (code <= 7'd3)                        c = 3'd1;
    else if (code <= 7'd7)                   c = 3'd2;
    else if (code >= 7'd10 && code <= 7'd13) c = 3'd3;
    else if (code >= 7'd14 && code <= 7'd17) c = 3'd4;
    else if (code >= 7'd20 && code <= 7'd22) c = 3'd5;
    else if (code >= 7'd23 && code <= 7'd25) c = 3'd6;
    return c;
  endfunction

endpackage

// File: rtl/vending_inventory.sv
// rtl/vending_inventory.sv - per-slot stock counters indexed by decimal item code
module vending_inventory
  import vending_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n,
  input  logic       reload,
  input  logic       dec,
  input  logic [4:0] idx,
  output logic [3:0] count
);

  // Full 32-entry array so any 5-bit index reads a defined value; slots above MAX_CODE stay empty.
  logic [3:0] stock [32];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < 32; i++) stock[i] <= 4'd0;
    end else if (reload) begin
      for (int i = 0; i < 32; i++) stock[i] <= (i <= MAX_CODE) ? 4'(STOCK_PER_ITEM) : 4'd0;
    end else if (dec && stock[idx] != 4'd0) begin
      stock[idx] <= stock[idx] - 4'd1;
    end
  end

  assign count = stock[idx];

endmodule

// File: rtl/vending_machine.sv
// rtl/vending_machine.sv - card/keypad transaction FSM with registered outputs
module vending_machine
  import vending_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RELOAD,
  input  logic       CARD_IN,
  input  logic [2:0] ITEM_CODE,
  input  logic       KEY_PRESS,
  input  logic       VALID_TRAN,
  output logic       VEND,
  output logic       INVALID_SEL,
  output logic [2:0] COST,
  output logic       FAILED_TRAN
);

  state_t           state_q, state_d;
  logic [2:0]       tens_q, tens_d, units_q, units_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       code;
  logic [3:0]       stock_cnt;
  logic             timeout;
  logic             vend_d, inv_d, fail_d;
  logic [2:0]       cost_d;

  assign code    = 7'(tens_q) * 7'd10 + 7'(units_q);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  vending_inventory u_inv (
    .clk     (CLK),
    .clear_n (RESET),
    .reload  (state_q == RELOAD_ST),
    .dec     (state_q == VEND_ST),
    .idx     (code[4:0]),
    .count   (stock_cnt)
  );

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (RELOAD)       state_d = RELOAD_ST;
        else if (CARD_IN) state_d = GET_D1;
      end
      RELOAD_ST: state_d = IDLE;
      GET_D1: begin
        if (KEY_PRESS) begin
          tens_d  = ITEM_CODE;
          cnt_d   = '0;
          state_d = GET_D2;
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = INVALID_ST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GET_D2: begin
        if (KEY_PRESS) begin
          units_d = ITEM_CODE;
          cnt_d   = '0;
          state_d = CHECK;
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = INVALID_ST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        cnt_d   = '0;
        state_d = (code_in_range(code) && stock_cnt != 4'd0) ? WAIT_VALID : INVALID_ST;
      end
      WAIT_VALID: begin
        if (VALID_TRAN) begin
          state_d = VEND_ST;
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = FAIL_ST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registers line up with the state they describe.
    vend_d = (state_d == VEND_ST);
    inv_d  = (state_d == INVALID_ST);
    fail_d = (state_d == FAIL_ST);
    cost_d = (state_d == WAIT_VALID || state_d == VEND_ST) ? cost_of(code) : 3'd0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      tens_q      <= '0;
      units_q     <= '0;
      cnt_q       <= '0;
      VEND        <= 1'b0;
      INVALID_SEL <= 1'b0;
      FAILED_TRAN <= 1'b0;
      COST        <= 3'd0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      cnt_q       <= cnt_d;
      VEND        <= vend_d;
      INVALID_SEL <= inv_d;
      FAILED_TRAN <= fail_d;
      COST        <= cost_d;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// tb/tb_vending_machine.sv - scoreboard bench for vending_machine
module tb_vending_machine;
  import vending_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET, RELOAD, CARD_IN, KEY_PRESS, VALID_TRAN;
  logic [2:0] ITEM_CODE;
  logic       VEND, INVALID_SEL, FAILED_TRAN;
  logic [2:0] COST;

  int checks   = 0;
  int failures = 0;

  // Expected strobe events: {VEND, INVALID_SEL, FAILED_TRAN, COST}
  logic [5:0] exp_q [$];
  logic [5:0] act_ev;
  logic [5:0] exp_ev;

  localparam logic [2:0] EV_VEND = 3'b100;
  localparam logic [2:0] EV_INV  = 3'b010;
  localparam logic [2:0] EV_FAIL = 3'b001;

  always #5 CLK = ~CLK;

  vending_machine dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .RELOAD      (RELOAD),
    .CARD_IN     (CARD_IN),
    .ITEM_CODE   (ITEM_CODE),
    .KEY_PRESS   (KEY_PRESS),
    .VALID_TRAN  (VALID_TRAN),
    .VEND        (VEND),
    .INVALID_SEL (INVALID_SEL),
    .COST        (COST),
    .FAILED_TRAN (FAILED_TRAN)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: every strobe cycle must match the head of the expectation queue.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && (VEND || INVALID_SEL || FAILED_TRAN)) begin
      act_ev = {VEND, INVALID_SEL, FAILED_TRAN, COST};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=%b required=none", act_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev !== exp_ev) begin
          failures++;
          $display("FAIL event actual=%b required=%b", act_ev, exp_ev);
        end
      end
    end
  end

  task automatic card_digits(input logic [2:0] d1, input logic [2:0] d2);
    CARD_IN = 1'b1;
    tick(1);
    CARD_IN   = 1'b0;
    KEY_PRESS = 1'b1;
    ITEM_CODE = d1;
    tick(1);
    ITEM_CODE = d2;
    tick(1);
    KEY_PRESS = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] d1, input logic [2:0] d2,
                         input logic ok, input logic [2:0] cost);
    exp_q.push_back(ok ? {EV_VEND, cost} : {EV_INV, 3'd0});
    card_digits(d1, d2);
    VALID_TRAN = 1'b1;
    tick(1);
    if (ok) begin
      check("wait_valid_cost", COST, cost);
      tick(1);
      VALID_TRAN = 1'b0;
      tick(1);
    end else begin
      check("invalid_cost", COST, 0);
      tick(1);
      VALID_TRAN = 1'b0;
    end
    tick(1);
  endtask

  task automatic do_reload();
    RELOAD = 1'b1;
    tick(1);
    RELOAD = 1'b0;
    tick(1);
  endtask

  // {d1, d2, ok, cost}
  logic [9:0] vecs [10];

  initial begin
    vecs[0] = {3'd0, 3'd0, 1'b1, 3'd1};
    vecs[1] = {3'd0, 3'd7, 1'b1, 3'd2};
    vecs[2] = {3'd1, 3'd3, 1'b1, 3'd3};
    vecs[3] = {3'd1, 3'd4, 1'b1, 3'd4};
    vecs[4] = {3'd2, 3'd0, 1'b1, 3'd5};
    vecs[5] = {3'd2, 3'd3, 1'b1, 3'd6};
    vecs[6] = {3'd2, 3'd5, 1'b1, 3'd6};
    vecs[7] = {3'd2, 3'd6, 1'b0, 3'd0};
    vecs[8] = {3'd2, 3'd7, 1'b0, 3'd0};
    vecs[9] = {3'd1, 3'd7, 1'b1, 3'd4};

    RESET = 1'b0; RELOAD = 1'b0; CARD_IN = 1'b0; KEY_PRESS = 1'b0;
    VALID_TRAN = 1'b0; ITEM_CODE = 3'd0;
    tick(2);
    check("rst_vend", VEND, 0);
    check("rst_invalid", INVALID_SEL, 0);
    check("rst_failed", FAILED_TRAN, 0);
    check("rst_cost", COST, 0);
    check("rst_stock22", dut.u_inv.stock[22], 0);
    RESET = 1'b1;
    tick(1);

    do_reload();
    check("reload_stock22", dut.u_inv.stock[22], 10);
    run_txn(3'd2, 3'd2, 1'b1, 3'd5);
    check("stock22_after_vend", dut.u_inv.stock[22], 9);

    for (int i = 0; i < 10; i++) begin
      logic [9:0] v;
      v = vecs[i];
      run_txn(v[9:7], v[6:4], v[3], v[2:0]);
    end

    // No bank approval: FAILED_TRAN after five waiting cycles
    exp_q.push_back({EV_FAIL, 3'd0});
    card_digits(3'd2, 3'd2);
    tick(7);

    // Approval on the last allowed cycle still vends
    exp_q.push_back({EV_VEND, 3'd5});
    card_digits(3'd2, 3'd2);
    tick(5);
    VALID_TRAN = 1'b1;
    tick(1);
    VALID_TRAN = 1'b0;
    tick(2);
    check("stock22_after_late_vend", dut.u_inv.stock[22], 8);

    // Second digit never arrives; late press in IDLE is ignored
    exp_q.push_back({EV_INV, 3'd0});
    CARD_IN = 1'b1;
    tick(1);
    CARD_IN = 1'b0;
    KEY_PRESS = 1'b1; ITEM_CODE = 3'd2;
    tick(1);
    KEY_PRESS = 1'b0;
    tick(6);
    KEY_PRESS = 1'b1;
    tick(1);
    KEY_PRESS = 1'b0;
    tick(2);
    check("late_press_idle", 32'(dut.state_q), 32'(IDLE));

    // Digit timeout with CARD_IN still high restarts a transaction (1,0 -> cost 3)
    exp_q.push_back({EV_INV, 3'd0});
    exp_q.push_back({EV_VEND, 3'd3});
    CARD_IN = 1'b1;
    tick(1);
    KEY_PRESS = 1'b1; ITEM_CODE = 3'd2;
    tick(1);
    KEY_PRESS = 1'b0;
    tick(7);
    CARD_IN = 1'b0;
    KEY_PRESS = 1'b1; ITEM_CODE = 3'd1;
    tick(1);
    ITEM_CODE = 3'd0;
    tick(1);
    KEY_PRESS = 1'b0; VALID_TRAN = 1'b1;
    tick(1);
    check("restart_cost", COST, 3);
    tick(1);
    VALID_TRAN = 1'b0;
    tick(2);

    // Asynchronous reset while waiting for the bank
    card_digits(3'd2, 3'd2);
    tick(2);
    check("pre_reset_cost", COST, 5);
    #2 RESET = 1'b0;
    #1;
    check("async_reset_cost", COST, 0);
    check("async_reset_state", 32'(dut.state_q), 32'(IDLE));
    check("async_reset_stock22", dut.u_inv.stock[22], 0);
    tick(1);
    RESET = 1'b1;
    tick(1);

    // Empty stock after reset: selection rejected
    run_txn(3'd2, 3'd2, 1'b0, 3'd0);

    // Drain slot 22: ten vends then a rejection
    do_reload();
    CARD_IN = 1'b1; VALID_TRAN = 1'b1;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(i < 10 ? {EV_VEND, 3'd5} : {EV_INV, 3'd0});
      tick(1);
      KEY_PRESS = 1'b1; ITEM_CODE = 3'd2;
      tick(2);
      KEY_PRESS = 1'b0;
      if (i < 10) begin
        tick(3);
      end else begin
        CARD_IN = 1'b0; VALID_TRAN = 1'b0;
        tick(2);
      end
    end
    check("stock22_drained", dut.u_inv.stock[22], 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
